anim_sequencer: RTL

- Upstream pacing and sequencing stage for the seven-segment animation display.
- Produces the frame index (the digit) and the animation select that the downstream segment decoders consume.
- Owns the prescaler, the per-animation frame limits and the automatic animation rotation.
- Adds a pause level and a step/skip button, replacing the free-running counter logic in the top level.

---
 rtl/anim_pkg.sv | 39 +++
 rtl/anim_sequencer_tick_prescaler.sv | 44 ++++
 rtl/anim_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/anim_pkg.sv
// anim_pkg: shared constants, animation frame limits and sequencer state
// encoding for the seven-segment animation sequencer.
//   FRAME_W / ANIM_W / PRESC_W : widths of frame index, animation index and prescaler
//   ANIM_COUNT, ANIM_1..ANIM_5 : animation indices (0-9 count, then five patterns)
//   seq_state_t                : RUN / HOLD / SKIP sequencing states
//   frame_max()                : last frame index of a given animation
package anim_pkg;

    localparam int unsigned FRAME_W = 4;
    localparam int unsigned ANIM_W  = 3;
    localparam int unsigned PRESC_W = 24;

    localparam logic [ANIM_W-1:0] ANIM_COUNT = 3'd0;
    localparam logic [ANIM_W-1:0] ANIM_1     = 3'd1;
    localparam logic [ANIM_W-1:0] ANIM_2     = 3'd2;
    localparam logic [ANIM_W-1:0] ANIM_3     = 3'd3;
    localparam logic [ANIM_W-1:0] ANIM_4     = 3'd4;
    localparam logic [ANIM_W-1:0] ANIM_5     = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_SKIP = 2'd2
    } seq_state_t;

    // Unknown animation indices fall back to the 0-9 count length.
    function automatic logic [FRAME_W-1:0] frame_max(input logic [ANIM_W-1:0] anim);
        logic [FRAME_W-1:0] limit;
        limit = 4'd9;
        case (anim)
            ANIM_COUNT:             limit = 4'd9;
            ANIM_1, ANIM_2, ANIM_3: limit = 4'd6;
            ANIM_4, ANIM_5:         limit = 4'd5;
            default:                limit = 4'd9;
        endcase
        return limit;
    endfunction

endpackage

// File: rtl/anim_sequencer_tick_prescaler.sv
// tick_prescaler: 24-bit frame-rate prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (counter holds when low)
//   clr        : synchronous clear, wins over en
//   speed_sel  : 0 selects MAX_COUNT, otherwise compare = speed_sel * 1024
//   tick       : combinational, high on the enabled cycle the counter wraps
//   count      : current counter value
module tick_prescaler
    import anim_pkg::*;
#(
    parameter logic [PRESC_W-1:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [7:0]         speed_sel,
    output logic               tick,
    output logic [PRESC_W-1:0] count
);

    logic [PRESC_W-1:0] compare;
    logic               at_limit;

    always_comb begin
        compare = (speed_sel == 8'd0) ? MAX_COUNT : {6'b0, speed_sel, 10'b0};
    end

    // >= rather than == so a compare lowered below the running count
    // wraps on the next enabled cycle instead of rolling through 2^24.
    assign at_limit = (count >= compare);
    assign tick     = en && at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_limit ? '0 : count + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// anim_sequencer: paces and sequences the seven-segment animations.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : global enable, all sequencing state holds when low
//   speed_sel    : prescaler speed override (0 = MAX_COUNT)
//   pause        : async level, freezes sequencing while high
//   step_btn     : async button; manual tick while paused, skip to next animation otherwise
//   frame        : frame index for the segment decoder
//   anim_sel     : animation index 0..NUM_ANIMS-1
//   frame_tick   : one-cycle pulse on every frame change
//   seq_done     : one-cycle pulse when the rotation wraps back to animation 0
//   prescale_lsb : prescaler bits [7:0] for debug
module anim_sequencer
    import anim_pkg::*;
#(
    parameter logic [PRESC_W-1:0] MAX_COUNT   = 24'd10_000_000,
    parameter int unsigned        NUM_ANIMS   = 6,
    parameter int unsigned        SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         speed_sel,
    input  logic               pause,
    input  logic               step_btn,
    output logic [FRAME_W-1:0] frame,
    output logic [ANIM_W-1:0]  anim_sel,
    output logic               frame_tick,
    output logic               seq_done,
    output logic [7:0]         prescale_lsb
);

    localparam logic [ANIM_W-1:0] LAST_ANIM = ANIM_W'(NUM_ANIMS - 1);

    logic [SYNC_STAGES-1:0] pause_ff;
    logic [SYNC_STAGES-1:0] step_ff;
    logic                   step_prev;
    logic                   pause_s;
    logic                   step_edge;

    seq_state_t         state, state_nxt;
    logic [FRAME_W-1:0] frame_nxt;
    logic [ANIM_W-1:0]  anim_nxt;
    logic               tick_nxt, done_nxt;
    logic               adv_frame, adv_anim;
    logic               anim_wrap, frame_wrap;
    logic [ANIM_W-1:0]  anim_inc;

    logic               presc_en, presc_clr, presc_tick;
    logic [PRESC_W-1:0] presc_count;
    logic               unused_count_hi;

    // Synchronisers and edge register run regardless of ena so edges seen
    // while disabled are consumed rather than replayed on re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_ff  <= '0;
            step_ff   <= '0;
            step_prev <= 1'b0;
        end else begin
            pause_ff  <= {pause_ff[SYNC_STAGES-2:0], pause};
            step_ff   <= {step_ff[SYNC_STAGES-2:0], step_btn};
            step_prev <= step_ff[SYNC_STAGES-1];
        end
    end

    assign pause_s   = pause_ff[SYNC_STAGES-1];
    assign step_edge = step_ff[SYNC_STAGES-1] && !step_prev;

    // Pause and step both pre-empt a tick in RUN, so the counter must not
    // wrap on that cycle either.
    assign presc_en  = ena && (state == ST_RUN) && !pause_s && !step_edge;
    assign presc_clr = ena && (state == ST_SKIP);

    tick_prescaler #(
        .MAX_COUNT (MAX_COUNT)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (presc_en),
        .clr       (presc_clr),
        .speed_sel (speed_sel),
        .tick      (presc_tick),
        .count     (presc_count)
    );

    assign prescale_lsb    = presc_count[7:0];
    assign unused_count_hi = ^presc_count[PRESC_W-1:8];

    always_comb begin
        state_nxt  = state;
        frame_nxt  = frame;
        anim_nxt   = anim_sel;
        tick_nxt   = 1'b0;
        done_nxt   = 1'b0;
        adv_frame  = 1'b0;
        adv_anim   = 1'b0;
        anim_wrap  = (anim_sel >= LAST_ANIM);
        anim_inc   = anim_wrap ? '0 : anim_sel + ANIM_W'(1);
        frame_wrap = (frame >= frame_max(anim_sel));

        if (ena) begin
            case (state)
                ST_RUN: begin
                    if (pause_s) begin
                        state_nxt = ST_HOLD;
                    end else if (step_edge) begin
                        state_nxt = ST_SKIP;
                    end else if (presc_tick) begin
                        adv_frame = 1'b1;
                    end
                end
                ST_HOLD: begin
                    adv_frame = step_edge;
                    if (!pause_s) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_SKIP: begin
                    adv_anim  = 1'b1;
                    state_nxt = pause_s ? ST_HOLD : ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end

        // A frame step past frame_max turns into an animation advance.
        if (adv_frame && !frame_wrap) begin
            frame_nxt = frame + FRAME_W'(1);
            tick_nxt  = 1'b1;
        end else if (adv_frame || adv_anim) begin
            frame_nxt = '0;
            anim_nxt  = anim_inc;
            tick_nxt  = 1'b1;
            done_nxt  = anim_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            frame      <= '0;
            anim_sel   <= '0;
            frame_tick <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame      <= frame_nxt;
            anim_sel   <= anim_nxt;
            frame_tick <= tick_nxt;
            seq_done   <= done_nxt;
        end
    end

endmodule
